// File: rtl/voice_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg: shared types for the voice scheduler slice.
//   note_t / dur_t / age_t : default-width note number, duration, age
//   sched_state_e          : scheduler FSM states
//   voice_state_t          : snapshot of one voice (gate, freq, remaining, age)
// The DEF_* constants are the default widths; modules carry their own
// parameters so they can be built at other sizes.
// -----------------------------------------------------------------------------
package synth_pkg;

  localparam int unsigned DEF_FREQ_RES_BITS = 7;
  localparam int unsigned DEF_DUR_BITS      = 16;
  localparam int unsigned DEF_AGE_BITS      = 8;

  typedef logic [DEF_FREQ_RES_BITS-1:0] note_t;
  typedef logic [DEF_DUR_BITS-1:0]      dur_t;
  typedef logic [DEF_AGE_BITS-1:0]      age_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    ASSIGN = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic  gate;
    note_t freq;
    dur_t  remaining;
    age_t  age;
  } voice_state_t;

endpackage

// File: rtl/voice_scheduler_if.sv
// -----------------------------------------------------------------------------
// voice_scheduler_if: note-event valid/ready channel.
//   ev_valid    : event present (source -> scheduler)
//   ev_ready    : scheduler can accept (scheduler -> source)
//   ev_note     : note number, octave*12 + semitone
//   ev_duration : length in sample ticks, 0 = note-off
// Modports: master = event source, slave = scheduler.
// -----------------------------------------------------------------------------
interface voice_scheduler_if #(
  parameter int unsigned FREQ_RES_BITS = 7,
  parameter int unsigned DUR_BITS      = 16
);
  logic                     ev_valid;
  logic                     ev_ready;
  logic [FREQ_RES_BITS-1:0] ev_note;
  logic [DUR_BITS-1:0]      ev_duration;

  modport master (output ev_valid, output ev_note, output ev_duration, input ev_ready);
  modport slave  (input ev_valid, input ev_note, input ev_duration, output ev_ready);
endinterface

// File: rtl/voice_scheduler_slot.sv
// -----------------------------------------------------------------------------
// voice_slot: state of a single player voice.
//   clk_i, rst_ni   : clock, async active-low reset
//   load_i          : start note_i for dur_i ticks (gate=1, age=0)
//   release_i       : note-off, gate=0 and remaining=0
//   tick_i          : sample tick; gated voice counts down and ages
//   gate_o, freq_o, age_o : registered voice state
// load/release take precedence over the tick in the same cycle.
// -----------------------------------------------------------------------------
module voice_slot #(
  parameter int unsigned FREQ_RES_BITS = 7,
  parameter int unsigned DUR_BITS      = 16,
  parameter int unsigned AGE_BITS      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     load_i,
  input  logic                     release_i,
  input  logic                     tick_i,
  input  logic [FREQ_RES_BITS-1:0] note_i,
  input  logic [DUR_BITS-1:0]      dur_i,
  output logic                     gate_o,
  output logic [FREQ_RES_BITS-1:0] freq_o,
  output logic [AGE_BITS-1:0]      age_o
);

  logic                     gate_q, gate_d;
  logic [FREQ_RES_BITS-1:0] freq_q, freq_d;
  logic [DUR_BITS-1:0]      rem_q, rem_d;
  logic [AGE_BITS-1:0]      age_q, age_d;

  // Next voice state: load > release > tick countdown.
  always_comb begin
    gate_d = gate_q;
    freq_d = freq_q;
    rem_d  = rem_q;
    age_d  = age_q;
    if (load_i) begin
      gate_d = 1'b1;
      freq_d = note_i;
      rem_d  = dur_i;
      age_d  = {AGE_BITS{1'b0}};
    end else if (release_i) begin
      gate_d = 1'b0;
      rem_d  = {DUR_BITS{1'b0}};
    end else if (tick_i && gate_q) begin
      // The tick that takes remaining to zero also drops the gate.
      if (rem_q <= DUR_BITS'(1)) begin
        gate_d = 1'b0;
        rem_d  = {DUR_BITS{1'b0}};
      end else begin
        gate_d = 1'b1;
        rem_d  = rem_q - DUR_BITS'(1);
      end
      if (age_q != {AGE_BITS{1'b1}}) begin
        age_d = age_q + AGE_BITS'(1);
      end else begin
        age_d = age_q;
      end
    end else begin
      gate_d = gate_q;
    end
  end

  // Voice state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gate_q <= 1'b0;
      freq_q <= {FREQ_RES_BITS{1'b0}};
      rem_q  <= {DUR_BITS{1'b0}};
      age_q  <= {AGE_BITS{1'b0}};
    end else begin
      gate_q <= gate_d;
      freq_q <= freq_d;
      rem_q  <= rem_d;
      age_q  <= age_d;
    end
  end

  assign gate_o = gate_q;
  assign freq_o = freq_q;
  assign age_o  = age_q;

endmodule

// File: rtl/voice_scheduler.sv
// -----------------------------------------------------------------------------
// voice_scheduler: allocates note events onto NUM_VOICES player voices.
//   mclk, rst_n    : master clock, async active-low reset
//   ev (slave)     : note event channel (valid/ready, note, duration)
//   voice_freq     : per-voice note number, voice v at [v*FREQ_RES_BITS +: FREQ_RES_BITS]
//   voice_gate     : voice sounding
//   voice_restart  : 1-cycle pulse, player resets its sample index
//   steal          : 1-cycle pulse when a busy voice was displaced
//   active_count   : registered popcount of voice_gate (one cycle behind)
// Optional (macro VOICE_SCHED_STATS_EN): steal_count, drop_count saturating
// 16-bit counters of steals and unmatched note-offs.
// An accepted event is scanned against one voice per cycle, then assigned
// with priority match > free > oldest.
// -----------------------------------------------------------------------------
module voice_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES    = 4,
  parameter int unsigned FREQ_RES_BITS = 7,
  parameter int unsigned DUR_BITS      = 16,
  parameter int unsigned TICK_DIV      = 256,
  parameter int unsigned AGE_BITS      = 8
) (
  input  logic                                mclk,
  input  logic                                rst_n,
  voice_scheduler_if.slave                    ev,
  output logic [NUM_VOICES*FREQ_RES_BITS-1:0] voice_freq,
  output logic [NUM_VOICES-1:0]               voice_gate,
  output logic [NUM_VOICES-1:0]               voice_restart,
  output logic                                steal,
  output logic [$clog2(NUM_VOICES):0]         active_count
`ifdef VOICE_SCHED_STATS_EN
  ,
  output logic [15:0]                         steal_count,
  output logic [15:0]                         drop_count
`endif
);

  localparam int unsigned IDX_W   = $clog2(NUM_VOICES);
  localparam int unsigned ACT_W   = IDX_W + 1;
  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  sched_state_e             state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [FREQ_RES_BITS-1:0] note_q, note_d;
  logic [DUR_BITS-1:0]      dur_q, dur_d;
  logic                     match_found_q, match_found_d;
  logic [IDX_W-1:0]         match_idx_q, match_idx_d;
  logic                     free_found_q, free_found_d;
  logic [IDX_W-1:0]         free_idx_q, free_idx_d;
  logic [IDX_W-1:0]         oldest_idx_q, oldest_idx_d;
  logic [AGE_BITS-1:0]      oldest_age_q, oldest_age_d;
  logic [PRESC_W-1:0]       presc_q, presc_d;
  logic [NUM_VOICES-1:0]    restart_q, restart_d;
  logic                     steal_q, steal_d;
  logic [ACT_W-1:0]         active_q, active_d;

  logic                     tick_s;
  logic [IDX_W-1:0]         target_s;
  logic [NUM_VOICES-1:0]    load_s;
  logic [NUM_VOICES-1:0]    release_s;
  logic [NUM_VOICES-1:0]    slot_gate;
  logic [FREQ_RES_BITS-1:0] slot_freq [NUM_VOICES];
  logic [AGE_BITS-1:0]      slot_age  [NUM_VOICES];

  assign ev.ev_ready = (state_q == IDLE);

  // Sample-tick prescaler; tick is high on the wrapping count.
  always_comb begin
    tick_s = (presc_q == PRESC_W'(TICK_DIV - 1));
    if (tick_s) begin
      presc_d = {PRESC_W{1'b0}};
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ev.ev_valid) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = ASSIGN;
        end else begin
          state_d = SCAN;
        end
      end
      ASSIGN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Event latch and scan trackers; each SCAN cycle folds in voice idx_q.
  always_comb begin
    idx_d         = idx_q;
    note_d        = note_q;
    dur_d         = dur_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    oldest_idx_d  = oldest_idx_q;
    oldest_age_d  = oldest_age_q;
    if (state_q == IDLE) begin
      if (ev.ev_valid) begin
        note_d        = ev.ev_note;
        dur_d         = ev.ev_duration;
        idx_d         = {IDX_W{1'b0}};
        match_found_d = 1'b0;
        match_idx_d   = {IDX_W{1'b0}};
        free_found_d  = 1'b0;
        free_idx_d    = {IDX_W{1'b0}};
        oldest_idx_d  = {IDX_W{1'b0}};
        oldest_age_d  = {AGE_BITS{1'b0}};
      end else begin
        idx_d = idx_q;
      end
    end else if (state_q == SCAN) begin
      idx_d = idx_q + IDX_W'(1);
      if (!match_found_q && slot_gate[idx_q] && (slot_freq[idx_q] == note_q)) begin
        match_found_d = 1'b1;
        match_idx_d   = idx_q;
      end else begin
        match_found_d = match_found_q;
      end
      if (!free_found_q && !slot_gate[idx_q]) begin
        free_found_d = 1'b1;
        free_idx_d   = idx_q;
      end else begin
        free_found_d = free_found_q;
      end
      // Strictly-greater keeps the lowest index on equal ages.
      if ((idx_q == {IDX_W{1'b0}}) || (slot_age[idx_q] > oldest_age_q)) begin
        oldest_idx_d = idx_q;
        oldest_age_d = slot_age[idx_q];
      end else begin
        oldest_idx_d = oldest_idx_q;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // FSM outputs: voice strobes and pulse requests issued in ASSIGN.
  always_comb begin
    load_s    = {NUM_VOICES{1'b0}};
    release_s = {NUM_VOICES{1'b0}};
    restart_d = {NUM_VOICES{1'b0}};
    steal_d   = 1'b0;
    if (match_found_q) begin
      target_s = match_idx_q;
    end else if (free_found_q) begin
      target_s = free_idx_q;
    end else begin
      target_s = oldest_idx_q;
    end
    if (state_q == ASSIGN) begin
      if (dur_q != {DUR_BITS{1'b0}}) begin
        load_s[target_s]    = 1'b1;
        restart_d[target_s] = 1'b1;
        steal_d             = !match_found_q && !free_found_q;
      end else if (match_found_q) begin
        release_s[match_idx_q] = 1'b1;
      end else begin
        steal_d = 1'b0;
      end
    end else begin
      steal_d = 1'b0;
    end
  end

  // Population count of the registered gates.
  always_comb begin
    active_d = {ACT_W{1'b0}};
    for (int v = 0; v < int'(NUM_VOICES); v++) begin
      active_d = active_d + ACT_W'(slot_gate[v]);
    end
  end

  // Scheduler state registers.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= {IDX_W{1'b0}};
      note_q        <= {FREQ_RES_BITS{1'b0}};
      dur_q         <= {DUR_BITS{1'b0}};
      match_found_q <= 1'b0;
      match_idx_q   <= {IDX_W{1'b0}};
      free_found_q  <= 1'b0;
      free_idx_q    <= {IDX_W{1'b0}};
      oldest_idx_q  <= {IDX_W{1'b0}};
      oldest_age_q  <= {AGE_BITS{1'b0}};
      presc_q       <= {PRESC_W{1'b0}};
      restart_q     <= {NUM_VOICES{1'b0}};
      steal_q       <= 1'b0;
      active_q      <= {ACT_W{1'b0}};
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      note_q        <= note_d;
      dur_q         <= dur_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      oldest_idx_q  <= oldest_idx_d;
      oldest_age_q  <= oldest_age_d;
      presc_q       <= presc_d;
      restart_q     <= restart_d;
      steal_q       <= steal_d;
      active_q      <= active_d;
    end
  end

  for (genvar v = 0; v < int'(NUM_VOICES); v++) begin : g_slot
    voice_slot #(
      .FREQ_RES_BITS(FREQ_RES_BITS),
      .DUR_BITS     (DUR_BITS),
      .AGE_BITS     (AGE_BITS)
    ) u_slot (
      .clk_i    (mclk),
      .rst_ni   (rst_n),
      .load_i   (load_s[v]),
      .release_i(release_s[v]),
      .tick_i   (tick_s),
      .note_i   (note_q),
      .dur_i    (dur_q),
      .gate_o   (slot_gate[v]),
      .freq_o   (slot_freq[v]),
      .age_o    (slot_age[v])
    );
    assign voice_freq[v*FREQ_RES_BITS +: FREQ_RES_BITS] = slot_freq[v];
  end

  assign voice_gate    = slot_gate;
  assign voice_restart = restart_q;
  assign steal         = steal_q;
  assign active_count  = active_q;

`ifdef VOICE_SCHED_STATS_EN
  logic [15:0] steal_cnt_q;
  logic [15:0] drop_cnt_q;
  logic        drop_s;

  // A note-off that found no sounding voice with its note is a drop.
  always_comb begin
    drop_s = (state_q == ASSIGN) && (dur_q == {DUR_BITS{1'b0}}) && !match_found_q;
  end

  // Saturating steal/drop statistics.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      steal_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      if (steal_d && (steal_cnt_q != 16'hFFFF)) begin
        steal_cnt_q <= steal_cnt_q + 16'd1;
      end
      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign steal_count = steal_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

endmodule
